template_sad_accumulator: RTL
=============================

TEMPLATE_SAD_ACCUMULATOR -- requirements
Module: template_sad_accumulator

Interface
REQ-001 SHALL have parameter PIXEL_SIZE, default 8, pixel bit width.
REQ-002 SHALL have parameter LINE_SIZE, default 16, pixels per line.
REQ-003 SHALL have parameter NUM_TEMPLATES, default 4, templates compared in parallel.
REQ-004 SHALL have parameter WINDOW_LINES, default 8, lines per match window.
REQ-005 SHALL have port CLK  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  begin a new window.
REQ-008 SHALL have port in_valid  input  1  I_line/T_line valid this cycle.
REQ-009 SHALL have port I_line  input  [PIXEL_SIZE-1:0] x LINE_SIZE  image line from input_buffer I_out_line.
REQ-010 SHALL have port T_line  input  [PIXEL_SIZE-1:0] x LINE_SIZE x NUM_TEMPLATES  template lines from input_buffer T_out_line.
REQ-011 SHALL have port busy  output  1  high while in ACCUM.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse, results valid.
REQ-013 SHALL have port sad_out  output  [SAD_W-1:0] x NUM_TEMPLATES  window SAD per template.
REQ-014 SHALL have port best_idx  output  [$clog2(NUM_TEMPLATES)-1:0]  index of minimum SAD.
REQ-015 SHALL have port best_sad  output  [SAD_W-1:0]  minimum SAD value.

Function
REQ-016 SHALL compute per template line_sum = sum over pixels of |I_line[j] - T_line[j][k]|, width PIXEL_SIZE+$clog2(LINE_SIZE), unsigned, no truncation.
REQ-017 SHALL size SAD_W = PIXEL_SIZE+$clog2(LINE_SIZE)+$clog2(WINDOW_LINES); accumulation never overflows, no saturation logic.
REQ-018 SHALL implement FSM states IDLE and ACCUM plus line counter cnt (0..WINDOW_LINES-1).
REQ-019 SHALL, on start=1 in any state, clear accumulators, enter ACCUM; if in_valid=1 same cycle, that line is accumulated as line 1 (cnt=1), else cnt=0.
REQ-020 SHALL, in ACCUM with start=0 and in_valid=1, add line_sum to each accumulator and increment cnt.
REQ-021 SHALL, in ACCUM with in_valid=0, hold accumulators and cnt (gaps allowed, unlimited).
REQ-022 SHALL ignore in_valid in IDLE when start=0.
REQ-023 SHALL, on the edge accepting line WINDOW_LINES, register sad_out = acc+line_sum, assert out_valid for exactly the following cycle, return to IDLE, clear cnt.
REQ-024 SHALL register best_idx/best_sad on the same edge as sad_out; ties resolve to lowest index.
REQ-025 SHALL hold sad_out/best_idx/best_sad stable until the next window completes.
REQ-026 SHALL treat start during ACCUM as abort-and-restart; no out_valid for the aborted window.
REQ-027 SHALL support WINDOW_LINES=1 (every accepted line after start completes a window).

Reset
REQ-028 SHALL, while RST_N=0, force IDLE, cnt=0, accumulators 0, busy=0, out_valid=0, sad_out=0, best_idx=0, best_sad=0, regardless of CLK.
REQ-029 SHALL, on reset mid-window, discard partial results; first window after reset requires start.

Configuration
REQ-030 SHALL compile the argmin comparator only when macro TEMPLATE_SAD_BEST_MATCH_EN is defined.
REQ-031 SHALL, without TEMPLATE_SAD_BEST_MATCH_EN, keep ports best_idx/best_sad present but tied to 0; sad_out and out_valid unchanged.

Structure
REQ-032 SHALL take PIXEL_SIZE, LINE_SIZE, NUM_TEMPLATES defaults and SAD width helper functions from shared package template_match_pkg.
REQ-033 SHALL instantiate per template one sub-module abs_diff_line_sum (combinational |a-b| plus adder tree over LINE_SIZE).

Verification (LINE_SIZE=4, NUM_TEMPLATES=2, WINDOW_LINES=3)
REQ-034 SHALL test: start+3 lines, I=10, T0=10, T1=12 -> out_valid one cycle after 3rd line edge, sad_out={0,24}, best_idx=0, best_sad=0.
REQ-035 SHALL test: I=255, T0=0, T1=0 for 3 lines -> sad_out={3060,3060}, best_idx=0 (tie), no overflow.
REQ-036 SHALL test: lines with 2-cycle in_valid gaps, I=5, T0=9, T1=6 -> sad_out={48,12}, best_idx=1, busy high throughout.
REQ-037 SHALL test: RST_N low after 2 lines -> all outputs 0 asynchronously, no out_valid; new start+3 lines gives correct sums.
REQ-038 SHALL test: start re-asserted after 2 lines -> no out_valid for first window; result reflects only lines after restart.
REQ-039 SHALL test: build without TEMPLATE_SAD_BEST_MATCH_EN, scenario of REQ-036 -> sad_out={48,12}, best_idx=0, best_sad=0.

Source files
------------

// File: rtl/template_match_pkg.sv
// Shared defaults, state encoding and width helpers for the template-matching datapath.
// Used by template_sad_accumulator (argmin gated by TEMPLATE_SAD_BEST_MATCH_EN).
package template_match_pkg;

  localparam int DEFAULT_PIXEL_SIZE    = 8;
  localparam int DEFAULT_LINE_SIZE     = 16;
  localparam int DEFAULT_NUM_TEMPLATES = 4;
  localparam int DEFAULT_WINDOW_LINES  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sad_state_t;

  // One line's SAD: a full-scale difference on every pixel must still fit.
  function automatic int line_sum_width(input int pixel_size, input int line_size);
    return pixel_size + $clog2(line_size);
  endfunction

  function automatic int sad_width(input int pixel_size, input int line_size,
                                   input int window_lines);
    return line_sum_width(pixel_size, line_size) + $clog2(window_lines);
  endfunction

  // Never returns 0 so single-entry counters and indices stay legal vectors.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/abs_diff_line_sum.sv
// Combinational sum of absolute pixel differences across one line,
// built as a balanced adder tree padded to a power-of-two leaf count.
module abs_diff_line_sum
  import template_match_pkg::*;
#(
  parameter int PIXEL_SIZE = DEFAULT_PIXEL_SIZE,
  parameter int LINE_SIZE  = DEFAULT_LINE_SIZE,
  localparam int SUM_W     = line_sum_width(PIXEL_SIZE, LINE_SIZE)
) (
  input  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0] a,
  input  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0] b,
  output logic [SUM_W-1:0]                     sum
);

  localparam int LEAVES = 1 << $clog2(LINE_SIZE);

  logic [SUM_W-1:0] diff [LEAVES];

  genvar i;
  for (i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < LINE_SIZE) begin : g_pix
      assign diff[i] = SUM_W'((a[i] > b[i]) ? (a[i] - b[i]) : (b[i] - a[i]));
    end else begin : g_pad
      assign diff[i] = '0;
    end
  end

  // In-place reduction: each pass halves the live width, so a slot is read before it is overwritten.
  always_comb begin
    logic [SUM_W-1:0] tree [LEAVES];
    for (int j = 0; j < LEAVES; j++) begin
      tree[j] = diff[j];
    end
    for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        tree[j] = tree[2*j] + tree[2*j+1];
      end
    end
    sum = tree[0];
  end

endmodule

// File: rtl/template_sad_accumulator.sv
// Accumulates per-template line SADs over a window and reports the totals.
// Define TEMPLATE_SAD_BEST_MATCH_EN to build the argmin (best_idx/best_sad); otherwise they read 0.
module template_sad_accumulator
  import template_match_pkg::*;
#(
  parameter int PIXEL_SIZE    = DEFAULT_PIXEL_SIZE,
  parameter int LINE_SIZE     = DEFAULT_LINE_SIZE,
  parameter int NUM_TEMPLATES = DEFAULT_NUM_TEMPLATES,
  parameter int WINDOW_LINES  = DEFAULT_WINDOW_LINES,
  localparam int SAD_W        = sad_width(PIXEL_SIZE, LINE_SIZE, WINDOW_LINES),
  localparam int IDX_W        = index_width(NUM_TEMPLATES)
) (
  input  logic                                                CLK,
  input  logic                                                RST_N,
  input  logic                                                start,
  input  logic                                                in_valid,
  input  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                I_line,
  input  logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][PIXEL_SIZE-1:0] T_line,
  output logic                                                busy,
  output logic                                                out_valid,
  output logic [NUM_TEMPLATES-1:0][SAD_W-1:0]                 sad_out,
  output logic [IDX_W-1:0]                                    best_idx,
  output logic [SAD_W-1:0]                                    best_sad
);

  localparam int LS_W  = line_sum_width(PIXEL_SIZE, LINE_SIZE);
  localparam int CNT_W = index_width(WINDOW_LINES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_LINES - 1);

  sad_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [NUM_TEMPLATES-1:0][SAD_W-1:0] acc, acc_next, window_sum;
  logic [NUM_TEMPLATES-1:0][LS_W-1:0]  line_sum;
  logic accept;
  logic done;

  genvar k;
  for (k = 0; k < NUM_TEMPLATES; k++) begin : g_tmpl
    abs_diff_line_sum #(
      .PIXEL_SIZE(PIXEL_SIZE),
      .LINE_SIZE (LINE_SIZE)
    ) u_line_sum (
      .a  (I_line),
      .b  (T_line[k]),
      .sum(line_sum[k])
    );
  end

  // A start discards the old totals, so the incoming line sits on a zero base.
  always_comb begin
    for (int t = 0; t < NUM_TEMPLATES; t++) begin
      window_sum[t] = (start ? '0 : acc[t]) + SAD_W'(line_sum[t]);
    end
  end

  assign accept = in_valid && (start || (state == ACCUM));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc;
    done       = 1'b0;
    if (start) begin
      state_next = ACCUM;
      cnt_next   = '0;
      acc_next   = '0;
    end
    if (accept) begin
      if (start ? (WINDOW_LINES == 1) : (cnt == LAST_CNT)) begin
        done       = 1'b1;
        state_next = IDLE;
        cnt_next   = '0;
        acc_next   = '0;
      end else begin
        cnt_next = start ? CNT_W'(1) : cnt + CNT_W'(1);
        acc_next = window_sum;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      acc   <= acc_next;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      sad_out   <= '0;
    end else begin
      out_valid <= done;
      if (done) begin
        sad_out <= window_sum;
      end
    end
  end

  assign busy = (state == ACCUM);

`ifdef TEMPLATE_SAD_BEST_MATCH_EN
  logic [IDX_W-1:0] min_idx;
  logic [SAD_W-1:0] min_sad;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_idx = '0;
    min_sad = window_sum[0];
    for (int t = 1; t < NUM_TEMPLATES; t++) begin
      if (window_sum[t] < min_sad) begin
        min_sad = window_sum[t];
        min_idx = IDX_W'(t);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      best_idx <= '0;
      best_sad <= '0;
    end else if (done) begin
      best_idx <= min_idx;
      best_sad <= min_sad;
    end
  end
`else
  assign best_idx = '0;
  assign best_sad = '0;
`endif

endmodule
